clause_bin_loader: RTL and testbench

- Upstream feeder for the clause cell array: accepts clauses from the bin stream over a valid/ready handshake.
- Validates each clause, computes its literal count, and writes it into the next free clause cell.
- Drives the shared clause bus and a one-hot write strobe per cell; reports completion, fill level and sticky error flags to the bin controller.

---
 rtl/clause_bin_loader.sv | 145 ++++++++++++++
 tb/tb_clause_bin_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_bin_loader.sv
// Bin-stream clause loader: validates incoming clauses, counts literals and
// writes each accepted clause into the next free clause cell via a one-hot strobe.
module clause_bin_loader #(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 8,
    localparam int CW = NUM_VARS * 2,
    localparam int NW = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CW-1:0]          in_clause_i,
    input  logic                   in_last_i,
    output logic [NUM_CLAUSES-1:0] wr_o,
    output logic [CW-1:0]          clause_o,
    output logic [4:0]             clause_len_o,
    output logic [NW-1:0]          loaded_cnt_o,
    output logic                   full_o,
    output logic                   done_o,
    output logic                   err_empty_o,
    output logic                   err_illegal_o,
    output logic                   overflow_o,
    output logic [1:0]             dbg_state_o
);

    // Handshake: a clause word transfers on a rising clk edge where
    // in_valid_i && in_ready_o; in_ready_o is high only in LOAD.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_clause;
    logic [4:0]    r_len;
    logic [NW-1:0] r_cnt;
    logic          r_last;
    logic          r_err_empty;
    logic          r_err_illegal;
    logic          r_overflow;

    logic [4:0]    w_len;
    logic          w_illegal;
    logic          w_xfer;
    logic          w_start;
    logic          w_drop;
    logic [NW-1:0] w_cnt_inc;
    logic          w_cnt_full;

    always_comb begin
        w_len     = '0;
        w_illegal = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (in_clause_i[2*i +: 2] == 2'b11) begin
                w_illegal = 1'b1;
            end else if (in_clause_i[2*i +: 2] != 2'b00) begin
                w_len = w_len + 5'd1;
            end
        end
    end

    assign w_xfer     = in_valid_i && (r_state == LOAD);
    assign w_start    = start_i && ((r_state == IDLE) || (r_state == DONE));
    // An illegal code takes precedence over an empty literal count.
    assign w_drop     = w_illegal || (w_len == 5'd0);
    assign w_cnt_inc  = r_cnt + NW'(1);
    assign w_cnt_full = (w_cnt_inc == NW'(NUM_CLAUSES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = LOAD;
            LOAD: begin
                if (w_xfer) begin
                    if (!w_drop)        w_next = WRITE;
                    else if (in_last_i) w_next = DONE;
                end
            end
            WRITE:   w_next = (r_last || w_cnt_full) ? DONE : LOAD;
            DONE:    if (start_i) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clause      <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_last        <= 1'b0;
            r_err_empty   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt         <= '0;
                r_err_empty   <= 1'b0;
                r_err_illegal <= 1'b0;
                r_overflow    <= 1'b0;
            end
            if (w_xfer) begin
                if (w_illegal) begin
                    r_err_illegal <= 1'b1;
                end else if (w_len == 5'd0) begin
                    r_err_empty <= 1'b1;
                end else begin
                    r_clause <= in_clause_i;
                    r_len    <= w_len;
                    r_last   <= in_last_i;
                end
            end
            if (r_state == WRITE) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_full && !r_last) r_overflow <= 1'b1;
            end
        end
    end

    // Strobe is decoded from the state register so reset clears it immediately.
    assign wr_o          = (r_state == WRITE) ? ({{(NUM_CLAUSES-1){1'b0}}, 1'b1} << r_cnt) : '0;
    assign in_ready_o    = (r_state == LOAD);
    assign done_o        = (r_state == DONE);
    assign clause_o      = r_clause;
    assign clause_len_o  = r_len;
    assign loaded_cnt_o  = r_cnt;
    assign full_o        = (r_cnt == NW'(NUM_CLAUSES));
    assign err_empty_o   = r_err_empty;
    assign err_illegal_o = r_err_illegal;
    assign overflow_o    = r_overflow;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_clause_bin_loader.sv
// Bench for clause_bin_loader: randomized clause bins against a reference model,
// with a scoreboard monitor checking every write strobe.
module tb_clause_bin_loader;

    localparam int NV = 8;
    localparam int NC = 8;
    localparam int CW = NV * 2;
    localparam int NW = $clog2(NC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [CW-1:0] in_clause_i = '0;
    logic          in_last_i = 1'b0;
    logic [NC-1:0] wr_o;
    logic [CW-1:0] clause_o;
    logic [4:0]    clause_len_o;
    logic [NW-1:0] loaded_cnt_o;
    logic          full_o;
    logic          done_o;
    logic          err_empty_o;
    logic          err_illegal_o;
    logic          overflow_o;
    logic [1:0]    dbg_state_o;

    clause_bin_loader #(.NUM_VARS(NV), .NUM_CLAUSES(NC)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_clause_i(in_clause_i), .in_last_i(in_last_i),
        .wr_o(wr_o), .clause_o(clause_o), .clause_len_o(clause_len_o),
        .loaded_cnt_o(loaded_cnt_o), .full_o(full_o), .done_o(done_o),
        .err_empty_o(err_empty_o), .err_illegal_o(err_illegal_o),
        .overflow_o(overflow_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected write entries: {strobe, clause, length}
    logic [NC+CW+5-1:0] exp_q[$];

    int m_cnt;
    bit m_empty, m_ill, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int lit_count(input logic [CW-1:0] w);
        int n = 0;
        for (int i = 0; i < NV; i++)
            if (w[2*i +: 2] == 2'b01 || w[2*i +: 2] == 2'b10) n++;
        return n;
    endfunction

    function automatic bit has_illegal(input logic [CW-1:0] w);
        for (int i = 0; i < NV; i++)
            if (w[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // kind: 0 valid, 1 empty, 2 illegal
    function automatic logic [CW-1:0] rand_word(input int kind);
        logic [CW-1:0] w = '0;
        int k;
        if (kind == 1) return w;
        for (int i = 0; i < NV; i++) w[2*i +: 2] = 2'($urandom_range(0, 2));
        if (kind == 0 && lit_count(w) == 0) w[1:0] = 2'b01;
        if (kind == 2) begin
            k = $urandom_range(0, NV - 1);
            w[2*k +: 2] = 2'b11;
        end
        return w;
    endfunction

    // Reference behaviour of one accepted word; term says the bin is finished.
    task automatic model_xfer(input logic [CW-1:0] w, input bit last, output bit term);
        logic [NC-1:0] strobe;
        term = 1'b0;
        if (has_illegal(w)) begin
            m_ill = 1'b1;
            term  = last;
        end else if (lit_count(w) == 0) begin
            m_empty = 1'b1;
            term    = last;
        end else begin
            strobe = '0;
            strobe[m_cnt] = 1'b1;
            exp_q.push_back({strobe, w, 5'(lit_count(w))});
            m_cnt++;
            if (last) term = 1'b1;
            else if (m_cnt == NC) begin
                m_ovf = 1'b1;
                term  = 1'b1;
            end
        end
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [NC+CW+5-1:0] e;
        if (rst && wr_o !== '0) begin
            chk("ready_in_write", in_ready_o, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(wr_o), 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_o", 32'(wr_o), 32'(e[NC+CW+5-1 -: NC]));
                chk("clause_o", 32'(clause_o), 32'(e[CW+5-1 -: CW]));
                chk("clause_len_o", 32'(clause_len_o), 32'(e[4:0]));
            end
        end
    end

    // Called at a negedge; returns at a negedge after the transfer edge.
    task automatic send(input logic [CW-1:0] w, input bit last, output bit term);
        int t = 0;
        bit v, ok;
        ok   = 1'b0;
        term = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            in_valid_i  = 1'b0;
            in_clause_i = CW'($urandom);
            in_last_i   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        while (!ok && t < 40) begin
            v = (t == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid_i  = v;
            in_clause_i = v ? w : CW'($urandom);
            in_last_i   = v ? last : 1'($urandom_range(0, 1));
            #1;
            if (v && in_ready_o) begin
                ok = 1'b1;
                model_xfer(w, last, term);
            end
            @(negedge clk);
            t++;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        if (!ok) begin
            chk("handshake_timeout", 0, 1);
            term = 1'b1;
        end
    endtask

    task automatic start_bin();
        m_cnt   = 0;
        m_empty = 1'b0;
        m_ill   = 1'b0;
        m_ovf   = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_end();
        int t = 0;
        while (!done_o && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("done_o", done_o, 1);
        chk("loaded_cnt_o", 32'(loaded_cnt_o), m_cnt);
        chk("full_o", full_o, (m_cnt == NC));
        chk("err_empty_o", err_empty_o, m_empty);
        chk("err_illegal_o", err_illegal_o, m_ill);
        chk("overflow_o", overflow_o, m_ovf);
        chk("ready_in_done", in_ready_o, 0);
        chk("wr_in_done", 32'(wr_o), 0);
        chk("lost_clauses", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_bin(input logic [CW-1:0] ws[$], input bit ls[$]);
        bit term = 1'b0;
        start_bin();
        foreach (ws[i]) if (!term) send(ws[i], ls[i], term);
        check_end();
    endtask

    task automatic check_all_zero();
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_wr", 32'(wr_o), 0);
        chk("rst_clause", 32'(clause_o), 0);
        chk("rst_len", 32'(clause_len_o), 0);
        chk("rst_cnt", 32'(loaded_cnt_o), 0);
        chk("rst_full", full_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err_empty", err_empty_o, 0);
        chk("rst_err_illegal", err_illegal_o, 0);
        chk("rst_overflow", overflow_o, 0);
    endtask

    initial begin
        logic [CW-1:0] ws[$];
        bit ls[$];
        bit term;
        int n, kind;

        #12;
        check_all_zero();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", in_ready_o, 0);

        // Three valid clauses, last on the third; first has 3 literals.
        ws = '{16'h0884, rand_word(0), rand_word(0)};
        ls = '{0, 0, 1};
        run_bin(ws, ls);

        // Eight valid clauses with no last marker fill the array.
        ws.delete(); ls.delete();
        for (int i = 0; i < NC + 2; i++) begin
            ws.push_back(rand_word(0));
            ls.push_back(1'b0);
        end
        run_bin(ws, ls);

        // Empty clause between two valid ones.
        ws = '{rand_word(0), rand_word(1), rand_word(0)};
        ls = '{0, 0, 1};
        run_bin(ws, ls);

        // Illegal clause carrying the last marker.
        ws = '{rand_word(0), rand_word(2)};
        ls = '{0, 1};
        run_bin(ws, ls);

        // Exactly NC clauses with last on the final one: full without overflow.
        ws.delete(); ls.delete();
        for (int i = 0; i < NC; i++) begin
            ws.push_back(rand_word(0));
            ls.push_back(i == NC - 1);
        end
        run_bin(ws, ls);

        // Randomized bins.
        for (int b = 0; b < 20; b++) begin
            ws.delete(); ls.delete();
            n = $urandom_range(1, NC + 2);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 9);
                ws.push_back(rand_word(kind == 0 ? 1 : (kind == 1 ? 2 : 0)));
                ls.push_back(i == n - 1);
            end
            run_bin(ws, ls);
        end

        // Reset asserted while a write strobe is active.
        start_bin();
        send(rand_word(0), 1'b0, term);
        chk("pre_reset_wr", 32'(wr_o), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ws = '{rand_word(0), rand_word(0)};
        ls = '{0, 1};
        run_bin(ws, ls);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
